// File: rtl/sd_cmd_arbiter_pkg.sv
// Shared widths, defaults and FSM state encoding for the two-requester SD command arbiter.
package sd_cmd_arbiter_pkg;

    localparam int SD_LEN_W           = 23;
    localparam int SD_ADDR_W          = 32;
    localparam int SD_DATA_W          = 16;
    localparam int READ_WORDS_DEFAULT = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_XFER,
        ST_DONE,
        ST_ERR
    } arb_state_t;

endpackage

// File: rtl/sd_cmd_arbiter_if.sv
// One requester's command/data port; the requester holds the master side, the arbiter the slave side.
interface sd_cmd_arbiter_if;
    import sd_cmd_arbiter_pkg::*;

    logic                 cmd_trigger;
    logic                 cmd_write;
    logic [SD_LEN_W-1:0]  cmd_writeLen;
    logic [SD_ADDR_W-1:0] cmd_addr;
    logic                 cmd_accepted;
    logic [SD_DATA_W-1:0] dataIn;
    logic                 dataIn_accepted;
    logic                 dataOut_valid;
    logic                 done;
    logic                 err;

    modport master (
        output cmd_trigger, cmd_write, cmd_writeLen, cmd_addr, dataIn,
        input  cmd_accepted, dataIn_accepted, dataOut_valid, done, err
    );

    modport slave (
        input  cmd_trigger, cmd_write, cmd_writeLen, cmd_addr, dataIn,
        output cmd_accepted, dataIn_accepted, dataOut_valid, done, err
    );

endinterface

// File: rtl/sd_cmd_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins outright, a tie goes to whoever did not win last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       valid
);

    assign valid = |req;

    always_comb begin
        grant = last;
        if (req == 2'b11) begin
            grant = ~last;
        end else if (req[0]) begin
            grant = 1'b0;
        end else if (req[1]) begin
            grant = 1'b1;
        end
    end

endmodule

// File: rtl/sd_cmd_arbiter.sv
// Shares one SD controller command/data port between two requesters: grant, latch command,
// route the owner's data and handshakes, count words, and report done/err back to the owner.
module sd_cmd_arbiter
    import sd_cmd_arbiter_pkg::*;
#(
    parameter int READ_WORDS     = READ_WORDS_DEFAULT,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    sd_cmd_arbiter_if.slave      r0,
    sd_cmd_arbiter_if.slave      r1,
    output logic [SD_DATA_W-1:0] dataOut,
    output logic                 busy,
    output logic                 owner,
    output logic                 sd_cmd_trigger,
    input  logic                 sd_cmd_accepted,
    output logic                 sd_cmd_write,
    output logic [SD_LEN_W-1:0]  sd_cmd_writeLen,
    output logic [SD_ADDR_W-1:0] sd_cmd_addr,
    output logic [SD_DATA_W-1:0] sd_dataIn,
    input  logic                 sd_dataIn_accepted,
    input  logic [SD_DATA_W-1:0] sd_dataOut,
    input  logic                 sd_dataOut_valid,
    input  logic                 sd_err
);

    localparam int            TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit            T_EN   = (TIMEOUT_CYCLES > 0);
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    arb_state_t           state, state_next;
    logic                 grant, req_valid;
    logic                 sel_write;
    logic [SD_LEN_W-1:0]  sel_len;
    logic [SD_ADDR_W-1:0] sel_addr;
    logic [SD_LEN_W-1:0]  word_cnt;
    logic [TW-1:0]        idle_cnt;
    logic                 err_pending;
    logic                 active, handshake, xfer_strobe, timeout_hit;

    rr_arb2 u_rr (
        .req   ({r1.cmd_trigger, r0.cmd_trigger}),
        .last  (owner),
        .grant (grant),
        .valid (req_valid)
    );

    assign sel_write   = grant ? r1.cmd_write    : r0.cmd_write;
    assign sel_len     = grant ? r1.cmd_writeLen : r0.cmd_writeLen;
    assign sel_addr    = grant ? r1.cmd_addr     : r0.cmd_addr;

    assign active      = (state == ST_ISSUE) || (state == ST_XFER);
    assign handshake   = sd_cmd_accepted | sd_dataIn_accepted | sd_dataOut_valid;
    assign xfer_strobe = sd_cmd_write ? sd_dataIn_accepted : sd_dataOut_valid;
    assign timeout_hit = T_EN && active && !handshake && (idle_cnt == T_LAST);

    // sd_err outranks both acceptance and the final word, so a failing transfer never reports done
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    state_next = (sel_write && (sel_len == '0)) ? ST_ERR : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (sd_err || timeout_hit) begin
                    state_next = ST_ERR;
                end else if (sd_cmd_accepted) begin
                    state_next = ST_XFER;
                end
            end
            ST_XFER: begin
                if (sd_err || timeout_hit) begin
                    state_next = ST_ERR;
                end else if ((word_cnt == '0) || (xfer_strobe && (word_cnt == SD_LEN_W'(1)))) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            ST_ERR: begin
                if (!sd_err) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            owner           <= 1'b1;
            sd_cmd_trigger  <= 1'b0;
            sd_cmd_write    <= 1'b0;
            sd_cmd_writeLen <= '0;
            sd_cmd_addr     <= '0;
            word_cnt        <= '0;
            idle_cnt        <= '0;
            err_pending     <= 1'b0;
        end else begin
            state          <= state_next;
            sd_cmd_trigger <= (state_next == ST_ISSUE);
            err_pending    <= (state_next == ST_ERR) && (state != ST_ERR);
            if ((state == ST_IDLE) && req_valid) begin
                owner           <= grant;
                sd_cmd_write    <= sel_write;
                sd_cmd_writeLen <= sel_len;
                sd_cmd_addr     <= sel_addr;
            end
            if ((state == ST_ISSUE) && sd_cmd_accepted) begin
                word_cnt <= sd_cmd_write ? sd_cmd_writeLen : SD_LEN_W'(READ_WORDS);
            end else if ((state == ST_XFER) && xfer_strobe && (word_cnt != '0)) begin
                word_cnt <= word_cnt - SD_LEN_W'(1);
            end
            if (T_EN && active && !handshake) begin
                idle_cnt <= idle_cnt + TW'(1);
            end else begin
                idle_cnt <= '0;
            end
        end
    end

    assign busy      = (state != ST_IDLE);
    assign dataOut   = sd_dataOut;
    assign sd_dataIn = owner ? r1.dataIn : r0.dataIn;

    // Every strobe toward a requester is qualified by ownership and state, so the loser stays silent
    assign r0.cmd_accepted    = !owner && (state == ST_ISSUE) && sd_cmd_accepted;
    assign r1.cmd_accepted    =  owner && (state == ST_ISSUE) && sd_cmd_accepted;
    assign r0.dataIn_accepted = !owner && (state == ST_XFER) && sd_dataIn_accepted;
    assign r1.dataIn_accepted =  owner && (state == ST_XFER) && sd_dataIn_accepted;
    assign r0.dataOut_valid   = !owner && (state == ST_XFER) && sd_dataOut_valid;
    assign r1.dataOut_valid   =  owner && (state == ST_XFER) && sd_dataOut_valid;
    assign r0.done            = !owner && (state == ST_DONE);
    assign r1.done            =  owner && (state == ST_DONE);
    assign r0.err             = !owner && (state == ST_ERR) && err_pending;
    assign r1.err             =  owner && (state == ST_ERR) && err_pending;

endmodule

// File: tb/tb_sd_cmd_arbiter.sv
// Directed plus randomized bench for sd_cmd_arbiter against a transaction-level model of the
// round-robin grant, word counts, error and timeout rules.
module tb_sd_cmd_arbiter;
    import sd_cmd_arbiter_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 sd_cmd_accepted, sd_dataIn_accepted, sd_dataOut_valid, sd_err;
    logic [SD_DATA_W-1:0] sd_dataOut;
    logic [SD_DATA_W-1:0] dataOut, sd_dataIn;
    logic                 busy, owner, sd_cmd_trigger, sd_cmd_write;
    logic [SD_LEN_W-1:0]  sd_cmd_writeLen;
    logic [SD_ADDR_W-1:0] sd_cmd_addr;

    int          checks = 0;
    int          failures = 0;
    int          model_last;
    logic        req_wr[2];
    int          req_len[2];
    logic [31:0] req_addr[2];

    sd_cmd_arbiter_if rq0 ();
    sd_cmd_arbiter_if rq1 ();

    always #5 clk = ~clk;

    sd_cmd_arbiter #(.READ_WORDS(256), .TIMEOUT_CYCLES(16)) dut (
        .clk                (clk),
        .rst                (rst),
        .r0                 (rq0),
        .r1                 (rq1),
        .dataOut            (dataOut),
        .busy               (busy),
        .owner              (owner),
        .sd_cmd_trigger     (sd_cmd_trigger),
        .sd_cmd_accepted    (sd_cmd_accepted),
        .sd_cmd_write       (sd_cmd_write),
        .sd_cmd_writeLen    (sd_cmd_writeLen),
        .sd_cmd_addr        (sd_cmd_addr),
        .sd_dataIn          (sd_dataIn),
        .sd_dataIn_accepted (sd_dataIn_accepted),
        .sd_dataOut         (sd_dataOut),
        .sd_dataOut_valid   (sd_dataOut_valid),
        .sd_err             (sd_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rrPick(input bit q0, input bit q1, input int last);
        if (q0 && q1) return 1 - last;
        return q0 ? 0 : 1;
    endfunction

    function automatic logic accOf(input int w);
        return (w == 1) ? rq1.cmd_accepted : rq0.cmd_accepted;
    endfunction
    function automatic logic dinAccOf(input int w);
        return (w == 1) ? rq1.dataIn_accepted : rq0.dataIn_accepted;
    endfunction
    function automatic logic dvalOf(input int w);
        return (w == 1) ? rq1.dataOut_valid : rq0.dataOut_valid;
    endfunction
    function automatic logic doneOf(input int w);
        return (w == 1) ? rq1.done : rq0.done;
    endfunction
    function automatic logic errOf(input int w);
        return (w == 1) ? rq1.err : rq0.err;
    endfunction

    task automatic setReq(input int w, input logic wr, input int len, input logic [31:0] addr);
        req_wr[w] = wr; req_len[w] = len; req_addr[w] = addr;
        if (w == 1) begin
            rq1.cmd_write = wr; rq1.cmd_writeLen = SD_LEN_W'(len); rq1.cmd_addr = addr; rq1.cmd_trigger = 1'b1;
        end else begin
            rq0.cmd_write = wr; rq0.cmd_writeLen = SD_LEN_W'(len); rq0.cmd_addr = addr; rq0.cmd_trigger = 1'b1;
        end
    endtask

    task automatic dropReq(input int w);
        if (w == 1) rq1.cmd_trigger = 1'b0;
        else rq0.cmd_trigger = 1'b0;
    endtask

    task automatic resetDut();
        rst = 1'b1;
        sd_cmd_accepted = 0; sd_dataIn_accepted = 0; sd_dataOut_valid = 0; sd_err = 0; sd_dataOut = '0;
        rq0.cmd_trigger = 0; rq0.cmd_write = 0; rq0.cmd_writeLen = '0; rq0.cmd_addr = '0; rq0.dataIn = '0;
        rq1.cmd_trigger = 0; rq1.cmd_write = 0; rq1.cmd_writeLen = '0; rq1.cmd_addr = '0; rq1.dataIn = '0;
        tick();
        tick();
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_owner", 32'(owner), 1);
        checkOutput("rst_trigger", 32'(sd_cmd_trigger), 0);
        checkOutput("rst_addr", sd_cmd_addr, 0);
        checkOutput("rst_len", 32'(sd_cmd_writeLen), 0);
        checkOutput("rst_r0_done", 32'(rq0.done), 0);
        checkOutput("rst_r0_err", 32'(rq0.err), 0);
        rst = 1'b0;
        model_last = 1;
    endtask

    // Plays the controller for one transfer of requester 'who'; err_at >= 0 raises sd_err before that word
    task automatic applyStimulus(input int who, input int err_at);
        int n, remaining, words;
        logic [15:0] d;
        n = 0;
        while (sd_cmd_trigger !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checkOutput("cmd_trigger_raised", 32'(sd_cmd_trigger), 1);
        checkOutput("grant_owner", 32'(owner), who);
        checkOutput("cmd_write", 32'(sd_cmd_write), 32'(req_wr[who]));
        checkOutput("cmd_addr", sd_cmd_addr, req_addr[who]);
        if (req_wr[who]) checkOutput("cmd_len", 32'(sd_cmd_writeLen), req_len[who]);
        repeat ($urandom_range(0, 3)) tick();
        sd_cmd_accepted = 1'b1;
        #1;
        checkOutput("cmd_accepted_owner", 32'(accOf(who)), 1);
        checkOutput("cmd_accepted_other", 32'(accOf(1 - who)), 0);
        tick();
        sd_cmd_accepted = 1'b0;
        dropReq(who);
        checkOutput("cmd_trigger_dropped", 32'(sd_cmd_trigger), 0);
        model_last = who;
        remaining = req_wr[who] ? req_len[who] : 256;
        words = 0;
        while (remaining > 0) begin
            repeat ($urandom_range(0, 2)) tick();
            if (words == err_at) begin
                sd_err = 1'b1;
                tick();
                checkOutput("err_pulse", 32'(errOf(who)), 1);
                checkOutput("no_done_on_err", 32'(doneOf(who)), 0);
                tick();
                checkOutput("err_single_pulse", 32'(errOf(who)), 0);
                checkOutput("busy_in_err", 32'(busy), 1);
                sd_err = 1'b0;
                tick();
                checkOutput("idle_after_err", 32'(busy), 0);
                return;
            end
            d = 16'($urandom);
            if (req_wr[who]) begin
                if (who == 1) rq1.dataIn = d;
                else rq0.dataIn = d;
                sd_dataIn_accepted = 1'b1;
                #1;
                checkOutput("dataIn_mux", 32'(sd_dataIn), 32'(d));
                checkOutput("dinacc_owner", 32'(dinAccOf(who)), 1);
                checkOutput("dinacc_other", 32'(dinAccOf(1 - who)), 0);
            end else begin
                sd_dataOut = d;
                sd_dataOut_valid = 1'b1;
                #1;
                checkOutput("dataOut_pass", 32'(dataOut), 32'(d));
                checkOutput("dvalid_owner", 32'(dvalOf(who)), 1);
                checkOutput("dvalid_other", 32'(dvalOf(1 - who)), 0);
            end
            tick();
            sd_dataIn_accepted = 1'b0;
            sd_dataOut_valid = 1'b0;
            remaining--;
            words++;
            if (remaining > 0) checkOutput("no_early_done", 32'(doneOf(who)), 0);
        end
        checkOutput("done_pulse", 32'(doneOf(who)), 1);
        checkOutput("done_other", 32'(doneOf(1 - who)), 0);
        checkOutput("no_err_on_done", 32'(errOf(who)), 0);
        tick();
        checkOutput("done_single_pulse", 32'(doneOf(who)), 0);
        checkOutput("idle_after_done", 32'(busy), 0);
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n, pat, first;
        resetDut();

        setReq(0, 1'b0, 77, 32'd5);
        applyStimulus(rrPick(1, 0, model_last), -1);

        resetDut();
        setReq(0, 1'b1, $urandom_range(1, 6), $urandom);
        setReq(1, 1'b1, 3, $urandom);
        first = rrPick(1, 1, model_last);
        checkOutput("tie_after_reset_r0", first, 0);
        applyStimulus(first, -1);
        setReq(0, 1'b1, $urandom_range(1, 6), $urandom);
        applyStimulus(rrPick(1, 1, model_last), -1);
        applyStimulus(rrPick(1, 0, model_last), -1);

        setReq(0, 1'b0, 9, $urandom);
        applyStimulus(rrPick(1, 0, model_last), 100);

        setReq(1, 1'b1, 0, $urandom);
        tick();
        checkOutput("len0_err", 32'(rq1.err), 1);
        checkOutput("len0_no_trigger", 32'(sd_cmd_trigger), 0);
        checkOutput("len0_owner", 32'(owner), rrPick(0, 1, model_last));
        model_last = 1;
        dropReq(1);
        tick();
        checkOutput("len0_err_single", 32'(rq1.err), 0);
        checkOutput("len0_idle", 32'(busy), 0);
        checkOutput("len0_still_no_trigger", 32'(sd_cmd_trigger), 0);

        setReq(0, 1'b0, 1, $urandom);
        tick();
        checkOutput("to_trigger", 32'(sd_cmd_trigger), 1);
        n = 0;
        while (rq0.err !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checkOutput("timeout_cycles", n, 16);
        checkOutput("to_trigger_low", 32'(sd_cmd_trigger), 0);
        model_last = 0;
        dropReq(0);
        tick();
        checkOutput("to_idle", 32'(busy), 0);

        for (int i = 0; i < 6; i++) begin
            pat = $urandom_range(1, 3);
            if (pat[0]) setReq(0, ($urandom_range(0, 3) != 0), $urandom_range(1, 12), $urandom);
            if (pat[1]) setReq(1, ($urandom_range(0, 3) != 0), $urandom_range(1, 12), $urandom);
            first = rrPick(pat[0], pat[1], model_last);
            applyStimulus(first, -1);
            if (pat == 3) applyStimulus(1 - first, -1);
        end

        setReq(1, 1'b0, 4, $urandom);
        tick();
        checkOutput("rx_owner", 32'(owner), rrPick(0, 1, model_last));
        sd_cmd_accepted = 1'b1;
        tick();
        sd_cmd_accepted = 1'b0;
        dropReq(1);
        repeat (10) begin
            sd_dataOut_valid = 1'b1;
            tick();
        end
        rst = 1'b1;
        tick();
        checkOutput("rx_busy", 32'(busy), 0);
        checkOutput("rx_trigger", 32'(sd_cmd_trigger), 0);
        checkOutput("rx_dvalid", 32'(rq1.dataOut_valid), 0);
        checkOutput("rx_done", 32'(rq1.done), 0);
        checkOutput("rx_err", 32'(rq1.err), 0);
        checkOutput("rx_owner_reset", 32'(owner), 1);
        rst = 1'b0;
        sd_dataOut_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
